// File: rtl/hbm_arb_pkg.sv
// Shared types and constants for the HBM DMA write-channel arbiter and its
// read-side siblings.
package hbm_arb_pkg;

  localparam int DEF_BEAT_BYTES = 64;
  localparam int DATA_W         = 512;
  localparam int KEEP_W         = 64;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } arb_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] len;
  } wr_cmd_t;

  // Index width that stays legal for a single requester.
  function automatic int gnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hbm_dma_wr_arbiter_if.sv
// DMA write command and 512-bit data stream interfaces.
interface axis_mem_cmd;
  logic        valid;
  logic        ready;
  logic [63:0] address;
  logic [31:0] length;

  modport master (output valid, output address, output length, input ready);
  modport slave  (input valid, input address, input length, output ready);
endinterface

interface axi_stream;
  import hbm_arb_pkg::*;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;

  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping. Shared with the read-side arbiters.
module rr_arbiter import hbm_arb_pkg::*; #(
  parameter  int N = 4,
  localparam int W = gnt_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_oh,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  always_comb begin
    int k;
    k       = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!gnt_vld && req[k]) begin
        gnt_vld   = 1'b1;
        gnt_oh[k] = 1'b1;
        gnt_idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/hbm_dma_wr_arbiter.sv
// Shares the DMA write command + data channel between NUM_PORTS write-back
// engines; a granted port owns both until its last data beat.
module hbm_dma_wr_arbiter import hbm_arb_pkg::*; #(
  parameter  int NUM_PORTS  = 4,
  parameter  int BEAT_BYTES = DEF_BEAT_BYTES,
  localparam int GW         = gnt_w(NUM_PORTS)
) (
  input  logic                        hbm_clk,
  input  logic                        hbm_aresetn,
  input  logic [NUM_PORTS-1:0]        s_cmd_valid,
  output logic [NUM_PORTS-1:0]        s_cmd_ready,
  input  logic [NUM_PORTS*64-1:0]     s_cmd_address,
  input  logic [NUM_PORTS*32-1:0]     s_cmd_length,
  input  logic [NUM_PORTS-1:0]        s_data_valid,
  output logic [NUM_PORTS-1:0]        s_data_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] s_data_data,
  input  logic [NUM_PORTS*KEEP_W-1:0] s_data_keep,
  input  logic [NUM_PORTS-1:0]        s_data_last,
  axis_mem_cmd.master                 m_axis_dma_write_cmd,
  axi_stream.master                   m_axis_dma_write_data,
  output logic [GW-1:0]               grant_id,
  output logic                        busy,
  output logic                        err_len
);

  localparam int BSH = $clog2(BEAT_BYTES);

  logic [NUM_PORTS-1:0][63:0]     addr_a;
  logic [NUM_PORTS-1:0][31:0]     len_a;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_a;
  logic [NUM_PORTS-1:0][KEEP_W-1:0] keep_a;

  assign addr_a = s_cmd_address;
  assign len_a  = s_cmd_length;
  assign data_a = s_data_data;
  assign keep_a = s_data_keep;

  // Assert passes straight through; release is retimed so the FSM never
  // leaves IDLE on a partially-released reset.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
    if (!hbm_aresetn) rst_sync_q <= '0;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  arb_state_e             state_q, state_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]          grant_q, grant_d;
  wr_cmd_t                cmd_q, cmd_d;
  logic [32:0]            exp_beats_q, exp_beats_d;
  logic [32:0]            beat_cnt_q, beat_cnt_d;
  logic                   err_len_q, err_len_d;

  logic [NUM_PORTS-1:0]   arb_oh;
  logic [GW-1:0]          arb_idx;
  logic                   arb_vld;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req     (s_cmd_valid),
    .ptr     (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // 33-bit so a length of 0xFFFFFFFF does not wrap to zero beats.
  logic [32:0] exp_beats_calc;
  assign exp_beats_calc = ({1'b0, cmd_q.len} + 33'(BEAT_BYTES - 1)) >> BSH;

  logic              mc_valid;
  logic              md_valid;
  logic [DATA_W-1:0] md_data;
  logic [KEEP_W-1:0] md_keep;
  logic              md_last;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    cmd_d        = cmd_q;
    exp_beats_d  = exp_beats_q;
    beat_cnt_d   = beat_cnt_q;
    err_len_d    = err_len_q;
    s_cmd_ready  = '0;
    s_data_ready = '0;
    mc_valid     = 1'b0;
    md_valid     = 1'b0;
    md_data      = '0;
    md_keep      = '0;
    md_last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n_int && arb_vld) begin
          s_cmd_ready = arb_oh;
          grant_d     = arb_idx;
          cmd_d.addr  = addr_a[arb_idx];
          cmd_d.len   = len_a[arb_idx];
          state_d     = CMD;
        end
      end
      CMD: begin
        mc_valid = 1'b1;
        if (m_axis_dma_write_cmd.ready) begin
          rr_ptr_d    = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          exp_beats_d = exp_beats_calc;
          beat_cnt_d  = '0;
          state_d     = (cmd_q.len == '0) ? IDLE : DATA;
        end
      end
      DATA: begin
        md_valid              = s_data_valid[grant_q];
        md_data               = data_a[grant_q];
        md_keep               = keep_a[grant_q];
        md_last               = s_data_last[grant_q];
        s_data_ready[grant_q] = m_axis_dma_write_data.ready;
        if (md_valid && m_axis_dma_write_data.ready) begin
          beat_cnt_d = beat_cnt_q + 33'd1;
          if (md_last) begin
            state_d = IDLE;
            if ((beat_cnt_q + 33'd1) != exp_beats_q) err_len_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hbm_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cmd_q       <= '0;
      exp_beats_q <= '0;
      beat_cnt_q  <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cmd_q       <= cmd_d;
      exp_beats_q <= exp_beats_d;
      beat_cnt_q  <= beat_cnt_d;
      err_len_q   <= err_len_d;
    end
  end

  assign m_axis_dma_write_cmd.valid   = mc_valid;
  assign m_axis_dma_write_cmd.address = cmd_q.addr;
  assign m_axis_dma_write_cmd.length  = cmd_q.len;

  assign m_axis_dma_write_data.valid  = md_valid;
  assign m_axis_dma_write_data.data   = md_data;
  assign m_axis_dma_write_data.keep   = md_keep;
  assign m_axis_dma_write_data.last   = md_last;

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign err_len  = err_len_q;

endmodule

// File: tb/tb_hbm_dma_wr_arbiter.sv
// Randomised bench for hbm_dma_wr_arbiter: the bench plays the write-back
// engines and the DMA sink, and checks against a transaction-level model.
module tb_hbm_dma_wr_arbiter;

  localparam int N = 4;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic                  rstn;
  logic [N-1:0]          s_cmd_valid, s_cmd_ready;
  logic [N-1:0][63:0]    s_cmd_address;
  logic [N-1:0][31:0]    s_cmd_length;
  logic [N-1:0]          s_data_valid, s_data_ready, s_data_last;
  logic [N-1:0][511:0]   s_data_data;
  logic [N-1:0][63:0]    s_data_keep;
  logic [1:0]            grant_id;
  logic                  busy, err_len;

  axis_mem_cmd cmd_if ();
  axi_stream   dat_if ();

  hbm_dma_wr_arbiter #(.NUM_PORTS(N), .BEAT_BYTES(64)) dut (
    .hbm_clk               (gclk),
    .hbm_aresetn           (rstn),
    .s_cmd_valid           (s_cmd_valid),
    .s_cmd_ready           (s_cmd_ready),
    .s_cmd_address         (s_cmd_address),
    .s_cmd_length          (s_cmd_length),
    .s_data_valid          (s_data_valid),
    .s_data_ready          (s_data_ready),
    .s_data_data           (s_data_data),
    .s_data_keep           (s_data_keep),
    .s_data_last           (s_data_last),
    .m_axis_dma_write_cmd  (cmd_if),
    .m_axis_dma_write_data (dat_if),
    .grant_id              (grant_id),
    .busy                  (busy),
    .err_len               (err_len)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model: pending requests, rotating priority, sticky error.
  bit          pend [N];
  logic [63:0] m_addr [N];
  logic [31:0] m_len [N];
  int          m_ptr;
  bit          m_err;
  int          exp_order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [31:0] rand_len();
    int r;
    r = $urandom % 8;
    if (r == 0) return 32'd0;
    if (r == 1) return 32'd64;
    return 32'($urandom_range(1, 640));
  endfunction

  task automatic req(input int p, input logic [63:0] a, input logic [31:0] l);
    pend[p]          = 1'b1;
    m_addr[p]        = a;
    m_len[p]         = l;
    s_cmd_valid[p]   = 1'b1;
    s_cmd_address[p] = a;
    s_cmd_length[p]  = l;
  endtask

  task automatic rst_assert_chk();
    rstn        = 1'b0;
    s_cmd_valid = '1;
    #1;
    chk("rst_cmd_ready", s_cmd_ready, 0);
    chk("rst_data_ready", s_data_ready, 0);
    chk("rst_cmd_valid", cmd_if.valid, 0);
    chk("rst_data_valid", dat_if.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err_len", err_len, 0);
  endtask

  task automatic rst_release();
    repeat (2) @(negedge gclk);
    rstn         = 1'b1;
    s_cmd_valid  = '0;
    s_data_valid = '0;
    s_data_last  = '0;
    cmd_if.ready = 1'b0;
    dat_if.ready = 1'b0;
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
    repeat (3) @(negedge gclk);
  endtask

  // Entered at a negedge with requests driven; returns at the negedge of the
  // following IDLE cycle. mode: 0 random, 1 always ready, 2 ready toggles.
  task automatic xfer(input int stall, input int mode, input int delta,
                      input int rst_beat, output int g);
    int eg, nb, sent, idx, seen, cyc;
    logic [N-1:0] oh, er;
    g = -1;
    #1;
    chk("idle_busy", busy, 0);
    chk("err_len", err_len, m_err);
    eg  = pick();
    cyc = 0;
    while (s_cmd_ready == '0 && cyc < 20) begin
      @(negedge gclk); #1; cyc++;
    end
    if (s_cmd_ready == '0) begin
      chk("grant_timeout", 1, 0);
      return;
    end
    oh = '0;
    if (eg >= 0) oh[eg] = 1'b1;
    chk("grant_oh", s_cmd_ready, oh);
    chk("cmd_vld_idle", cmd_if.valid, 0);
    for (int p = 0; p < N; p++) if (s_cmd_ready[p] && g < 0) g = p;
    pend[g] = 1'b0;

    for (int i = 0; i <= stall; i++) begin
      @(negedge gclk);
      if (i == 0) s_cmd_valid[g] = 1'b0;
      cmd_if.ready = (i == stall);
      #1;
      chk("cmd_vld", cmd_if.valid, 1);
      chk("cmd_addr", cmd_if.address, m_addr[g]);
      chk("cmd_len", cmd_if.length, m_len[g]);
      chk("cmd_gid", grant_id, g);
      chk("cmd_busy", busy, 1);
      chk("cmd_sready", s_cmd_ready, 0);
      chk("cmd_dvld", dat_if.valid, 0);
      chk("cmd_dready", s_data_ready, 0);
    end
    m_ptr = (g + 1) % N;
    nb    = int'((longint'(m_len[g]) + 63) / 64);
    @(negedge gclk);
    cmd_if.ready = 1'b0;
    if (nb == 0) return;

    sent = nb + delta;
    if (sent < 1) sent = 1;
    idx = 0; seen = 0; cyc = 0;
    while (idx < sent && cyc < 400) begin
      for (int p = 0; p < N; p++) begin
        s_data_data[p] = rnd512();
        s_data_keep[p] = {$urandom(), $urandom()};
        if (p == g) begin
          s_data_valid[p] = (mode != 0) || ($urandom % 4 != 0);
          s_data_last[p]  = (idx == sent - 1);
        end else begin
          s_data_valid[p] = 1'($urandom % 2);
          s_data_last[p]  = 1'($urandom % 2);
        end
      end
      case (mode)
        1:       dat_if.ready = 1'b1;
        2:       dat_if.ready = (cyc % 2 == 0);
        default: dat_if.ready = ($urandom % 3 != 0);
      endcase
      if (idx == rst_beat) begin
        rst_assert_chk();
        return;
      end
      #1;
      chk("dat_vld", dat_if.valid, s_data_valid[g]);
      if (s_data_valid[g]) begin
        chk("dat_data", dat_if.data, s_data_data[g]);
        chk("dat_keep", dat_if.keep, s_data_keep[g]);
        chk("dat_last", dat_if.last, s_data_last[g]);
      end
      er = '0;
      er[g] = dat_if.ready;
      chk("dat_sready", s_data_ready, er);
      chk("dat_cready", s_cmd_ready, 0);
      if (dat_if.valid && dat_if.ready) seen++;
      if (s_data_valid[g] && dat_if.ready) idx++;
      cyc++;
      @(negedge gclk);
    end
    s_data_valid = '0;
    s_data_last  = '0;
    dat_if.ready = 1'b0;
    if (idx < sent) chk("data_timeout", 1, 0);
    chk("beats", seen, sent);
    if (sent != nb) m_err = 1'b1;
  endtask

  task automatic rand_round(input bit inj);
    int g, eg, d;
    bit any;
    any = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (!pend[p] && ($urandom % 2 == 1)) req(p, {$urandom(), $urandom()}, rand_len());
      if (pend[p]) any = 1'b1;
    end
    if (!any) req(int'($urandom % N), {$urandom(), $urandom()}, rand_len());
    eg = pick();
    d  = 0;
    if (inj && ($urandom % 5 == 0) && m_len[eg] > 32'd64) d = ($urandom % 2 == 1) ? 1 : -1;
    xfer(int'($urandom % 4), 0, d, -1, g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int g;
    s_cmd_valid   = '0;
    s_cmd_address = '0;
    s_cmd_length  = '0;
    s_data_valid  = '0;
    s_data_last   = '0;
    s_data_data   = '0;
    s_data_keep   = '0;
    cmd_if.ready  = 1'b0;
    dat_if.ready  = 1'b0;
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
    rstn  = 1'b1;
    #2;
    rst_assert_chk();
    rst_release();

    // all four ports contend continuously
    for (int p = 0; p < N; p++) req(p, 64'h1_0000 + 64'(p * 'h100), 32'd64);
    for (int t = 0; t < 5; t++) begin
      xfer(0, 1, 0, -1, g);
      chk("rr_order", g, exp_order[t]);
      if (t < 4) req(g, 64'h1_0000 + 64'(g * 'h100), 32'd64);
    end
    s_cmd_valid = '0;
    for (int p = 0; p < N; p++) pend[p] = 1'b0;

    req(1, 64'h1000, 32'd256);
    xfer(0, 1, 0, -1, g);
    chk("single_port", g, 1);

    req(2, 64'h2000, 32'd0);
    xfer(0, 1, 0, -1, g);
    chk("len0_port", g, 2);

    req(0, 64'h3000, 32'd256);
    req(3, 64'h4000, 32'd64);
    xfer(0, 1, 0, -1, g);
    chk("len0_ptr", g, 3);
    xfer(10, 2, 0, -1, g);
    chk("stall_port", g, 0);

    for (int r = 0; r < 20; r++) rand_round(1'b0);

    // abandon a transfer mid-data
    for (int p = 0; p < N; p++) if (pend[p]) begin
      s_cmd_valid[p] = 1'b0;
      pend[p] = 1'b0;
    end
    req(1, 64'h5000, 32'd256);
    xfer(0, 1, 0, 1, g);
    rst_release();
    req(1, 64'h5100, 32'd64);
    req(3, 64'h6000, 32'd256);
    xfer(0, 1, 0, -1, g);
    chk("post_rst_ptr", g, 1);
    xfer(0, 1, 0, -1, g);
    chk("post_rst_port3", g, 3);

    req(0, 64'h7000, 32'd200);
    xfer(0, 1, -1, -1, g);
    chk("short_port", g, 0);

    for (int r = 0; r < 15; r++) rand_round(1'b1);

    #1;
    chk("err_final", err_len, m_err);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
